// File: rtl/pipe_stage_fifo_pkg.sv
// Shared pipeline constants: bundle widths of each inter-stage buffer and
// the default buffer depth used when instantiating pipe_stage_fifo.
package pipe_stage_fifo_pkg;

  localparam int IF_ID_W   = 64;
  localparam int ID_EXE_W  = 150;
  localparam int EXE_MEM_W = 165;
  localparam int MEM_WB_W  = 70;

  localparam int STAGE_FIFO_DEPTH = 2;

endpackage

// File: rtl/pipe_stage_fifo.sv
// Inter-stage pipeline buffer: DEPTH-entry in-order circular buffer with a
// valid/allowin handshake on both sides, a stage-local stall and a flush.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH         = EXE_MEM_W,
  parameter int DEPTH         = STAGE_FIFO_DEPTH,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_allowin,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_allowin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Wrap explicitly so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  // A full buffer still accepts when the head leaves in the same cycle.
  always_comb begin
    valid      = (count_q != '0);
    out_valid  = valid && !hold;
    out_data   = mem[rd_ptr];
    in_allowin = (count_q != FULL) || (!hold && out_allowin);
    push       = in_valid && in_allowin && !flush;
    pop        = out_valid && out_allowin;
    count      = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Popped entries keep their contents; only reset or a zeroing flush clears.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset || (ZERO_ON_FLUSH && flush)) begin
        mem[i] <= '0;
      end else if (push && (wr_ptr == PW'(i))) begin
        mem[i] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench: four pipe_stage_fifo instances (depths 1/2/2/3, one
// without zeroing flush) share stimulus; a queue model scores each output.
module tb_pipe_stage_fifo;
  import pipe_stage_fifo_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         hold = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_allowin = 1'b0;

  logic         ia [N];
  logic         ov [N];
  logic         vl [N];
  logic [W-1:0] od [N];
  logic [0:0]   c0;
  logic [1:0]   c1, c2, c3;
  int           cnt [N];

  int           depth [N] = '{1, 2, 2, 3};
  int           mcnt [N];
  logic [W-1:0] exp_q [N][$];
  logic [W-1:0] data_exp [N];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(1), .ZERO_ON_FLUSH(1'b1)) dut_d1 (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_allowin(ia[0]), .in_data(in_data),
    .out_allowin(out_allowin), .out_valid(ov[0]), .out_data(od[0]),
    .valid(vl[0]), .count(c0));

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .ZERO_ON_FLUSH(1'b1)) dut_d2 (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_allowin(ia[1]), .in_data(in_data),
    .out_allowin(out_allowin), .out_valid(ov[1]), .out_data(od[1]),
    .valid(vl[1]), .count(c1));

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(2), .ZERO_ON_FLUSH(1'b0)) dut_d2s (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_allowin(ia[2]), .in_data(in_data),
    .out_allowin(out_allowin), .out_valid(ov[2]), .out_data(od[2]),
    .valid(vl[2]), .count(c2));

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(3), .ZERO_ON_FLUSH(1'b1)) dut_d3 (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_allowin(ia[3]), .in_data(in_data),
    .out_allowin(out_allowin), .out_valid(ov[3]), .out_data(od[3]),
    .valid(vl[3]), .count(c3));

  always_comb begin
    cnt[0] = int'(c0);
    cnt[1] = int'(c1);
    cnt[2] = int'(c2);
    cnt[3] = int'(c3);
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs at +1, then
  // advance the model at +3 (after the monitor has consumed any pop at +2).
  task automatic applyStimulus(input bit rst, input bit fl, input bit hd, input bit iv,
                               input logic [W-1:0] d, input bit oa, input bit chk_data = 1'b0);
    bit do_push [N];
    bit do_pop [N];
    @(negedge clk);
    reset = rst; flush = fl; hold = hd; in_valid = iv; in_data = d; out_allowin = oa;
    #1;
    for (int k = 0; k < N; k++) begin
      bit room;
      room = (mcnt[k] < depth[k]) || (!hd && oa);
      checkOutput($sformatf("k%0d in_allowin", k), W'(ia[k]), W'(room));
      checkOutput($sformatf("k%0d valid", k), W'(vl[k]), W'(mcnt[k] != 0));
      checkOutput($sformatf("k%0d out_valid", k), W'(ov[k]), W'(mcnt[k] != 0 && !hd));
      checkOutput($sformatf("k%0d count", k), W'(cnt[k]), W'(mcnt[k]));
      if (chk_data) checkOutput($sformatf("k%0d out_data", k), od[k], data_exp[k]);
      do_push[k] = iv && !fl && room;
      do_pop[k]  = (mcnt[k] != 0) && !hd && oa;
    end
    #2;
    for (int k = 0; k < N; k++) begin
      if (rst || fl) begin
        mcnt[k] = 0;
        exp_q[k].delete();
      end else begin
        mcnt[k] = mcnt[k] + int'(do_push[k]) - int'(do_pop[k]);
        if (do_push[k]) exp_q[k].push_back(d);
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < N; k++) data_exp[k] = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: every completed transfer must match the oldest accepted bundle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < N; k++) begin
        if (ov[k] && out_allowin) begin
          if (exp_q[k].size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL k%0d spurious pop: got 0x%0h, expected no transfer", k, od[k]);
          end else begin
            checkOutput($sformatf("k%0d head data", k), od[k], exp_q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) mcnt[k] = 0;
    doReset();

    // Streaming through an empty buffer: one-cycle latency, count stays 1.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Hold accumulates; third push refused on depth 2; release drains in order.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hA, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hB, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hC, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    // Fill, then simultaneous push/pop while full, then flush with a push offered.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hD, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hE, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hF, 1'b1);
    // Depth-2 non-zeroing copy wrote 1,2,3,A,B,D,E,C alternately from slot 0;
    // slot 0 last received E, which is what reappears at rd_ptr 0.
    data_exp[0] = '0;
    data_exp[1] = '0;
    data_exp[2] = 32'hE;
    data_exp[3] = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < 1200; i++) begin
      if (i == 600) begin
        doReset();
      end else begin
        applyStimulus(1'b0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised inter-stage pipeline buffer for the CPU pipeline: accepts a bundle from the upstream stage under a valid/allowin handshake and presents it to the downstream stage. It holds up to DEPTH bundles in order, supports a stage-local stall (`hold`) and a pipeline flush. It is the drop-in successor to the fixed single-entry stage registers: DEPTH=1, ZERO_ON_FLUSH=1 gives the existing single-register handshake behaviour.

## Interface
- WIDTH, 165, bundle width in bits (≥1).
- DEPTH, 2, entries held (≥1); CW = $clog2(DEPTH+1).
- ZERO_ON_FLUSH, 1, 1: flush and reset clear all storage to 0; 0: storage keeps stale contents.
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  discard all held and incoming bundles this cycle.
- hold  input  1  stall (e.g. AXI transaction outstanding); head may not leave while high.
- in_valid  input  1  upstream offers in_data.
- in_allowin  output  1  buffer can accept this cycle.
- in_data  input  WIDTH  upstream bundle.
- out_allowin  input  1  downstream accepts this cycle.
- out_valid  output  1  head bundle offered downstream.
- out_data  output  WIDTH  head bundle.
- valid  output  1  buffer non-empty, independent of hold.
- count  output  CW  entries held.

## Operation
- Storage: DEPTH×WIDTH registers as a circular buffer; rd_ptr, wr_ptr (mod DEPTH), count register.
- valid = (count != 0); out_valid = valid && !hold; out_data = mem[rd_ptr] (combinational read of registered storage).
- in_allowin = (count != DEPTH) || (!hold && out_allowin). Combinational path out_allowin→in_allowin is intentional.
- push = in_valid && in_allowin && !flush; pop = out_valid && out_allowin.
- push only: mem[wr_ptr] ← in_data, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1; if ZERO_ON_FLUSH, popped entry is not cleared (only flush/reset clear).
- push and pop: both pointers advance, count unchanged; legal when full.
- flush: count ← 0, rd_ptr ← wr_ptr ← 0, incoming bundle dropped; if ZERO_ON_FLUSH all entries ← 0. A pop in the flush cycle is still a completed transfer from the downstream's view.
- Priority: reset > flush > push/pop.
- Pointer wrap: increment from DEPTH−1 returns to 0; DEPTH need not be a power of two.
- count never exceeds DEPTH and never underflows by construction; verification asserts both.

## Timing
- Reset: count=0, pointers=0, storage=0; outputs valid=0, out_valid=0, out_data=0, count=0, in_allowin=1.
- Latency: bundle pushed in cycle N is at head (out_valid=1 if not held) in cycle N+1 when buffer was empty.
- Throughput: one push and one pop per cycle sustained.
- hold high: out_valid=0 same cycle; in_allowin stays 1 while count<DEPTH, so up to DEPTH bundles accumulate.
- flush in cycle N: valid=0, out_valid=0, count=0 from cycle N+1; in_allowin=1 at N+1.
- reset mid-operation: all content lost, same state as power-up reset next cycle.

## Structure
- Shared pipeline package holds bundle width constants (e.g. EXE_MEM_W=165, other stage widths) used for WIDTH at instantiation; no typedefs local to this block.
- Single module; pointer increment with wrap is a local function, no sub-module.

## Test plan
- Reset then idle: after reset, valid=0, out_valid=0, out_data=0, in_allowin=1, count=0.
- DEPTH=2, out_allowin=1, push 0x1,0x2,0x3 on consecutive cycles → out_data 0x1,0x2,0x3 in cycles 1–3, count stays 1.
- hold=1, push 0xA,0xB → count=2, in_allowin=0, out_valid=0; third push refused; release hold with out_allowin=1 → 0xA then 0xB out, in order.
- Full (count=2), hold=0, out_allowin=1, in_valid=1 with 0xC → simultaneous push/pop, count stays 2, head advances to next entry.
- count=2, flush=1 with in_valid=1 → next cycle count=0, out_valid=0, out_data=0 (ZERO_ON_FLUSH=1); with ZERO_ON_FLUSH=0 count=0 and storage retains old values.
- DEPTH=1 instance: in_allowin = !valid || (!hold && out_allowin) cycle-for-cycle over random in_valid/out_allowin/hold for 1000 cycles; DEPTH=3 random traffic checked against a scoreboard queue, wrap across pointer 2→0 exercised.
